// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe -- three-stage pipelined floating-point adder/subtractor
// for a small parameterised format {sign, exponent, mantissa}, bias
// 2^(EXP_W-1)-1, no subnormals (exponent 0 is a signed zero).
//
// Stages:  S1 unpack / classify / swap / align (guard, round, sticky)
//          S2 signed-magnitude add or subtract
//          S3 normalise / round / pack, registered onto result/flags
//
// Build option: define FP_ADDSUB_RNE_EN for round-to-nearest-even. Without
// it the block truncates toward zero and overflow saturates to max finite.
//
// Ports:
//   clk        single clock
//   rst_n      synchronous active-low reset
//   ena        global enable, low holds every stage
//   in_valid   operand pair offered
//   in_ready   operand pair accepted when in_valid && in_ready
//   a, b       operands, W = 1+EXP_W+MAN_W bits
//   op         0: a+b, 1: a-b
//   out_valid  result present
//   out_ready  consumer takes result when out_valid && out_ready
//   result     packed result
//   flags      {nan, ovf, unf, inexact}, aligned with result
module fp_addsub_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  // EW: hidden bit + mantissa + guard/round/sticky. SW adds a carry bit.
  localparam int EW     = MAN_W + 4;
  localparam int SW     = EW + 1;
  localparam int XW     = EXP_W + 2;
  localparam int EMAX_I = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] EMAX = '1;

  logic adv;
  logic v1, v2, v3;

  // One global stall: nothing moves while disabled or while the output is blocked.
  assign adv       = ena && !(v3 && !out_ready);
  assign in_ready  = rst_n && adv;
  assign out_valid = v3;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [MAN_W:0]   sig_a, sig_b;
  logic             swap;
  logic             l_s, s_s;
  logic [EXP_W-1:0] l_e, s_e, d;
  logic [MAN_W:0]   l_sig, s_sig;
  logic [EW-1:0]    ext_s, aligned;
  logic             sticky;
  int               d_i;

  assign sa = a[W-1];
  assign sb = b[W-1] ^ op;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);

  // Zero operands carry no significand, whatever their mantissa field holds.
  assign sig_a = a_zero ? '0 : {1'b1, fa};
  assign sig_b = b_zero ? '0 : {1'b1, fb};

  always_comb begin
    swap    = ({eb, sig_b} > {ea, sig_a});
    l_s     = swap ? sb : sa;
    s_s     = swap ? sa : sb;
    l_e     = swap ? eb : ea;
    s_e     = swap ? ea : eb;
    l_sig   = swap ? sig_b : sig_a;
    s_sig   = swap ? sig_a : sig_b;
    d       = l_e - s_e;
    d_i     = int'(d);
    ext_s   = {s_sig, 3'b000};
    sticky  = 1'b0;
    // Every bit shifted past the sticky position is folded into it; large
    // distances therefore leave only the sticky bit.
    for (int i = 0; i < EW; i++) begin
      if (i < d_i) sticky = sticky | ext_s[i];
    end
    aligned = (ext_s >> d) | {{(EW-1){1'b0}}, sticky};
  end

  logic             nan1, inf1, infs1, sl1, sub1, zneg1;
  logic [EXP_W-1:0] e1;
  logic [EW-1:0]    lsig1, ssig1;

  // ---------------- S2: signed-magnitude add/sub ----------------
  logic             nan2, inf2, infs2, sl2, zneg2;
  logic [EXP_W-1:0] e2;
  logic [SW-1:0]    sum2;
  logic [SW-1:0]    sum_c;

  // Swap guarantees |large| >= |small|, so the difference never goes negative.
  assign sum_c = sub1 ? ({1'b0, lsig1} - {1'b0, ssig1})
                      : ({1'b0, lsig1} + {1'b0, ssig1});

  // ---------------- S3: normalise, round, pack ----------------
  int                    lz;
  logic [EW-1:0]         norm;
  logic signed [XW-1:0]  exp_n, exp_r;
  logic                  inexact, rup;
  logic [MAN_W+1:0]      mr;
  logic [MAN_W-1:0]      mant_f;
  logic [W-1:0]          res_c;
  logic [3:0]            flg_c;

  always_comb begin
    lz = EW;
    for (int i = 0; i < EW; i++) begin
      if (sum2[i]) lz = EW - 1 - i;
    end
    if (sum2[SW-1]) begin
      norm  = sum2[SW-1:1] | {{(EW-1){1'b0}}, sum2[0]};
      exp_n = $signed({2'b00, e2}) + XW'(1);
    end else begin
      norm  = sum2[EW-1:0] << lz;
      exp_n = $signed({2'b00, e2}) - XW'(lz);
    end

    inexact = |norm[2:0];
`ifdef FP_ADDSUB_RNE_EN
    rup = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    rup = 1'b0;
`endif
    mr = {1'b0, 1'b1, norm[EW-2:3]} + {{(MAN_W+1){1'b0}}, rup};
    // Rounding carry out of the mantissa: renormalise by bumping the exponent.
    if (mr[MAN_W+1]) begin
      mant_f = mr[MAN_W:1];
      exp_r  = exp_n + XW'(1);
    end else begin
      mant_f = mr[MAN_W-1:0];
      exp_r  = exp_n;
    end

    res_c = {sl2, exp_r[EXP_W-1:0], mant_f};
    flg_c = {3'b000, inexact};
    if (nan2) begin
      res_c = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
      flg_c = 4'b1000;
    end else if (inf2) begin
      res_c = {infs2, EMAX, {MAN_W{1'b0}}};
      flg_c = 4'b0000;
    end else if (!norm[EW-1]) begin
      // Magnitude is exactly zero: only -0 + -0 keeps a negative sign.
      res_c = {zneg2, {(W-1){1'b0}}};
      flg_c = 4'b0000;
    end else if (exp_n <= XW'(0)) begin
      res_c = {sl2, {(W-1){1'b0}}};
      flg_c = 4'b0011;
    end else if (exp_r >= XW'(EMAX_I)) begin
`ifdef FP_ADDSUB_RNE_EN
      res_c = {sl2, EMAX, {MAN_W{1'b0}}};
`else
      res_c = {sl2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
      flg_c = 4'b0101;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (v2) begin
        result <= res_c;
        flags  <= flg_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      nan1  <= a_nan || b_nan || (a_inf && b_inf && (sa != sb));
      inf1  <= a_inf || b_inf;
      infs1 <= a_inf ? sa : sb;
      sl1   <= l_s;
      sub1  <= (l_s != s_s);
      zneg1 <= l_s & s_s;
      e1    <= l_e;
      lsig1 <= {l_sig, 3'b000};
      ssig1 <= aligned;

      nan2  <= nan1;
      inf2  <= inf1;
      infs2 <= infs1;
      sl2   <= sl1;
      zneg2 <= zneg1;
      e2    <= e1;
      sum2  <= sum_c;
    end
  end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 4, exponent field width; legal range 3..8.
REQ-002 The block SHALL have parameter MAN_W, default 3, stored mantissa field width; legal range 2..10.
REQ-003 The block SHALL define W = 1+EXP_W+MAN_W, operand format {sign, exponent, mantissa}, bias 2^(EXP_W-1)-1.
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have port ena, input, 1, global enable; low = pipeline hold.
REQ-007 The block SHALL have port in_valid, input, 1, operand pair offered.
REQ-008 The block SHALL have port in_ready, output, 1, operand pair accepted when in_valid && in_ready.
REQ-009 The block SHALL have port a, input, W, first operand.
REQ-010 The block SHALL have port b, input, W, second operand.
REQ-011 The block SHALL have port op, input, 1, 0 = a+b, 1 = a-b (b sign inverted).
REQ-012 The block SHALL have port out_valid, output, 1, result present.
REQ-013 The block SHALL have port out_ready, input, 1, consumer takes result when out_valid && out_ready.
REQ-014 The block SHALL have port result, output, W, packed sum.
REQ-015 The block SHALL have port flags, output, 4, {nan, ovf, unf, inexact}, aligned with result.

Function
REQ-016 The block SHALL be a 3-stage pipeline: S1 unpack/classify/swap/align, S2 signed magnitude add/sub, S3 normalise/round/pack; latency 3 cycles from accept to out_valid with no stall.
REQ-017 The block SHALL sustain one accepted pair per cycle while out_ready stays high.
REQ-018 The block SHALL stall all stages when ena=0 or (out_valid && !out_ready); in_ready = ena && !(out_valid && !out_ready).
REQ-019 The block SHALL hold result and flags stable while out_valid && !out_ready; no result is lost or duplicated; order preserved.
REQ-020 The block SHALL treat exponent 0 as signed zero (no subnormals; nonzero mantissa ignored).
REQ-021 The block SHALL treat exponent all-ones with mantissa 0 as infinity, nonzero mantissa as NaN.
REQ-022 The block SHALL output canonical NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0), nan=1, for any NaN input or inf plus opposite-signed inf.
REQ-023 The block SHALL pass a single infinity operand through with its effective sign, all flags 0.
REQ-024 The block SHALL align the smaller operand with guard, round and sticky bits; shift distance >= MAN_W+3 leaves only sticky.
REQ-025 The block SHALL return +0 for exact cancellation; equal-magnitude operands SHALL not produce a negative result.
REQ-026 The block SHALL output signed infinity with ovf=1, inexact=1 when the biased exponent after rounding reaches all-ones.
REQ-027 The block SHALL flush to signed zero with unf=1, inexact=1 when the normalised exponent falls to 0 or below.
REQ-028 The block SHALL set inexact=1 whenever any discarded guard/round/sticky bit is nonzero.
REQ-029 The block SHALL renormalise and increment the exponent when rounding carries out of the mantissa.

Reset
REQ-030 The block SHALL, on rst_n=0 at a clk edge, clear all stage valid bits; out_valid=0, result=0, flags=0, in_ready=0 during reset.
REQ-031 The block SHALL discard in-flight operations on reset mid-operation; first result after reset derives only from post-reset inputs.

Configuration
REQ-032 The block SHALL, with macro FP_ADDSUB_RNE_EN defined, round to nearest, ties to even.
REQ-033 The block SHALL, without FP_ADDSUB_RNE_EN, truncate toward zero; inexact still reported; overflow then saturates to max finite with ovf=1.

Verification (EXP_W=4, MAN_W=3)
REQ-034 The bench SHALL check a=0x38, b=0x38, op=0 -> result 0x40, flags 0, out_valid exactly 3 cycles after accept.
REQ-035 The bench SHALL check a=0x39, b=0x18, op=0 -> 0x3A, inexact=1 with FP_ADDSUB_RNE_EN; 0x39, inexact=1 without.
REQ-036 The bench SHALL check a=0x77, b=0x77, op=0 -> 0x78, ovf=1 (RNE build); 0x77, ovf=1 (truncate build).
REQ-037 The bench SHALL check a=0x38, b=0x38, op=1 -> 0x00, flags 0; a=0x78, b=0x78, op=1 -> 0x7C, nan=1.
REQ-038 The bench SHALL check streaming 6 pairs with out_ready low 5 cycles mid-stream -> in_ready low while blocked, all 6 results delivered in order, held stable.
REQ-039 The bench SHALL check rst_n low for one cycle with 2 ops in flight -> out_valid 0 next cycle; no stale result emitted.
